// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access controller: one read or write per request, waits on mem_ready.
// Optional wait-state abort is enabled with `define MEM_ACCESS_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, next_state;
    logic   we_q;
    logic   accept;
    logic   timeout_hit;

    assign accept = (state == IDLE) && req;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;

    // ready on the final wait cycle still completes the access normally
    assign timeout_hit = (state == REQ) && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
                err      <= 1'b0;
            end else if (timeout_hit) begin
                err      <= 1'b1;
            end else if (state == REQ && !mem_ready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req) next_state = REQ;
            REQ:     if (mem_ready || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            rdata     <= '0;
        end else begin
            if (accept) begin
                we_q      <= we;
                mem_addr  <= addr;
                mem_wdata <= wdata;
                mem_rd    <= ~we;
                mem_wr    <= we;
            end else if (state == REQ && next_state == DONE) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
            end
            if (state == REQ && mem_ready && !we_q) rdata <= mem_rdata;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
